simon_block_cipher: RTL and testbench

SIMON_BLOCK_CIPHER -- requirements
Module: simon_block_cipher

---
 rtl/simon_block_cipher.sv | 205 ++++++++++++++++++++
 tb/tb_simon_block_cipher.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_block_cipher.sv
// rtl/simon_block_cipher.sv - Simon block cipher core with on-chip key schedule
module simon_block_cipher #(
    parameter int WORD_W    = 16,
    parameter int KEY_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_we,
    input  logic [1:0]            key_idx,
    input  logic [WORD_W-1:0]     key_word,
    output logic                  key_ack,
    output logic                  key_ready,
    input  logic                  start,
    input  logic                  decrypt,
    input  logic [2*WORD_W-1:0]   block_in,
    output logic                  busy,
    output logic                  done,
    output logic [2*WORD_W-1:0]   block_out
);
    localparam bit LEGAL = (WORD_W == 16 && KEY_WORDS == 4) ||
                           ((WORD_W == 24 || WORD_W == 32) && (KEY_WORDS == 3 || KEY_WORDS == 4));

    if (!LEGAL) begin : g_illegal_params
        $error("simon_block_cipher: unsupported WORD_W/KEY_WORDS pair");
    end

    localparam int ROUNDS = (WORD_W == 16) ? 32 : (WORD_W == 24) ? 36 : (KEY_WORDS == 3) ? 42 : 44;
    localparam int CNT_W  = $clog2(ROUNDS);

    // z constants written first bit leftmost, so bit j of the sequence is Z[61-j]
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z_SEQ = (WORD_W == 16 || (WORD_W == 24 && KEY_WORDS == 3)) ? Z0 :
                                    (WORD_W == 24) ? Z1 : (KEY_WORDS == 3) ? Z2 : Z3;

    localparam logic [CNT_W-1:0] LAST  = CNT_W'(ROUNDS - 1);
    localparam logic [CNT_W-1:0] M_C   = CNT_W'(KEY_WORDS);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] THREE = CNT_W'(3);
    localparam logic [2:0]       KW3   = 3'(KEY_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_RUN} state_t;

    function automatic logic [WORD_W-1:0] rol(input logic [WORD_W-1:0] v, input int s);
        return (v << s) | (v >> (WORD_W - s));
    endfunction

    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] v, input int s);
        return rol(v, WORD_W - s);
    endfunction

    function automatic logic [WORD_W-1:0] f_round(input logic [WORD_W-1:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   rk_q [ROUNDS];
    logic [WORD_W-1:0]   rk_d [ROUNDS];
    logic [KEY_WORDS-1:0] key_loaded_q, key_loaded_d;
    logic                key_ack_q, key_ack_d;
    logic                key_ready_q, key_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                dec_q, dec_d;
    logic [WORD_W-1:0]   x_q, x_d, y_q, y_d;
    logic [2*WORD_W-1:0] block_out_q, block_out_d;

    logic                key_wr, start_ok;
    logic [WORD_W-1:0]   ks_tmp, ks_word, round_key, nx, ny;
    logic [5:0]          zpos;
    logic [CNT_W-1:0]    rk_sel;

    // Datapath: next key-schedule word at index cnt_q and one round of the block
    always_comb begin
        ks_tmp = ror(rk_q[cnt_q - ONE], 3);
        if (KEY_WORDS == 4) begin
            ks_tmp = ks_tmp ^ rk_q[cnt_q - THREE];
        end
        ks_tmp = ks_tmp ^ ror(ks_tmp, 1);
        // (i-m) never reaches 62 for any legal pair, so no wrap is needed
        zpos = 6'd61 - 6'(cnt_q - M_C);
        ks_word = ~rk_q[cnt_q - M_C] ^ ks_tmp ^ {{(WORD_W-1){1'b0}}, Z_SEQ[zpos]} ^ WORD_W'(3);

        rk_sel    = dec_q ? (LAST - cnt_q) : cnt_q;
        round_key = rk_q[rk_sel];
        if (dec_q) begin
            nx = y_q;
            ny = x_q ^ f_round(y_q) ^ round_key;
        end else begin
            nx = y_q ^ f_round(x_q) ^ round_key;
            ny = x_q;
        end
    end

    // Control: key writes, request capture, expansion and round sequencing
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rk_d         = rk_q;
        key_loaded_d = key_loaded_q;
        key_ack_d    = 1'b0;
        key_ready_d  = key_ready_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        dec_d        = dec_q;
        x_d          = x_q;
        y_d          = y_q;
        block_out_d  = block_out_q;

        // A valid key write always beats a coincident start
        key_wr   = key_we && ({1'b0, key_idx} < KW3);
        start_ok = start && !key_wr && (&key_loaded_q);

        case (state_q)
            ST_IDLE: begin
                if (key_wr) begin
                    rk_d[CNT_W'(key_idx)]  = key_word;
                    key_loaded_d[key_idx]  = 1'b1;
                    key_ack_d              = 1'b1;
                    key_ready_d            = 1'b0;
                end else if (start_ok) begin
                    x_d    = block_in[2*WORD_W-1:WORD_W];
                    y_d    = block_in[WORD_W-1:0];
                    dec_d  = decrypt;
                    busy_d = 1'b1;
                    if (key_ready_q) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_EXPAND;
                        cnt_d   = M_C;
                    end
                end
            end
            ST_EXPAND: begin
                rk_d[cnt_q] = ks_word;
                if (cnt_q == LAST) begin
                    key_ready_d = 1'b1;
                    state_d     = ST_RUN;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_RUN: begin
                x_d = nx;
                y_d = ny;
                if (cnt_q == LAST) begin
                    block_out_d = {nx, ny};
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; reset leaves an idle core with no key loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rk_q         <= '{default: '0};
            key_loaded_q <= '0;
            key_ack_q    <= 1'b0;
            key_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dec_q        <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            block_out_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rk_q         <= rk_d;
            key_loaded_q <= key_loaded_d;
            key_ack_q    <= key_ack_d;
            key_ready_q  <= key_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            dec_q        <= dec_d;
            x_q          <= x_d;
            y_q          <= y_d;
            block_out_q  <= block_out_d;
        end
    end

    assign key_ack   = key_ack_q;
    assign key_ready = key_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign block_out = block_out_q;

endmodule

// File: tb/tb_simon_block_cipher.sv
// tb/tb_simon_block_cipher.sv - scoreboard bench for simon_block_cipher
module tb_simon_block_cipher;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, key_we, start, decrypt;
    logic [1:0]  dsel, key_idx;
    logic [31:0] key_word;
    logic [63:0] block_in;

    logic        ack_a, rdy_a, busy_a, done_a;
    logic [31:0] out_a;
    logic        ack_b, rdy_b, busy_b, done_b;
    logic [63:0] out_b;
    logic        ack_c, rdy_c, busy_c, done_c;
    logic [47:0] out_c;

    logic        ack, rdy, busy, done;
    logic [63:0] bout;

    int          n_vec, n_bad;
    logic [63:0] exp_q[$];
    logic [127:0] key32, key64, key48;

    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

    simon_block_cipher #(.WORD_W(16), .KEY_WORDS(4)) u_dut16 (
        .clk(clk), .rst(rst), .key_we(key_we && dsel == 2'd0), .key_idx(key_idx),
        .key_word(key_word[15:0]), .key_ack(ack_a), .key_ready(rdy_a),
        .start(start && dsel == 2'd0), .decrypt(decrypt), .block_in(block_in[31:0]),
        .busy(busy_a), .done(done_a), .block_out(out_a));

    simon_block_cipher #(.WORD_W(32), .KEY_WORDS(4)) u_dut64 (
        .clk(clk), .rst(rst), .key_we(key_we && dsel == 2'd1), .key_idx(key_idx),
        .key_word(key_word), .key_ack(ack_b), .key_ready(rdy_b),
        .start(start && dsel == 2'd1), .decrypt(decrypt), .block_in(block_in),
        .busy(busy_b), .done(done_b), .block_out(out_b));

    simon_block_cipher #(.WORD_W(24), .KEY_WORDS(3)) u_dut48 (
        .clk(clk), .rst(rst), .key_we(key_we && dsel == 2'd2), .key_idx(key_idx),
        .key_word(key_word[23:0]), .key_ack(ack_c), .key_ready(rdy_c),
        .start(start && dsel == 2'd2), .decrypt(decrypt), .block_in(block_in[47:0]),
        .busy(busy_c), .done(done_c), .block_out(out_c));

    always_comb begin
        ack = ack_a; rdy = rdy_a; busy = busy_a; done = done_a; bout = {32'd0, out_a};
        if (dsel == 2'd1) begin
            ack = ack_b; rdy = rdy_b; busy = busy_b; done = done_b; bout = out_b;
        end else if (dsel == 2'd2) begin
            ack = ack_c; rdy = rdy_c; busy = busy_c; done = done_c; bout = {16'd0, out_c};
        end
    end

    function automatic logic [31:0] rl(input logic [31:0] v, input int s, input int n, input logic [31:0] m);
        return ((v << s) | (v >> (n - s))) & m;
    endfunction

    function automatic logic [31:0] fr(input logic [31:0] v, input int n, input logic [31:0] m);
        return (rl(v, 1, n, m) & rl(v, 8, n, m)) ^ rl(v, 2, n, m);
    endfunction

    // Reference Simon: whole key schedule up front, then a plain round loop
    function automatic logic [63:0] model(input int n, input int m, input logic [127:0] key,
                                          input logic [63:0] blk, input bit dec);
        logic [31:0] k [44];
        logic [31:0] mask, x, y, t;
        logic [61:0] z;
        int r;
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        if (n == 16) begin r = 32; z = Z0; end
        else if (n == 24) begin r = 36; z = (m == 3) ? Z0 : Z1; end
        else begin r = (m == 3) ? 42 : 44; z = (m == 3) ? Z2 : Z3; end
        for (int i = 0; i < m; i++) k[i] = key[32*i +: 32] & mask;
        for (int i = m; i < r; i++) begin
            t = rl(k[i-1], n - 3, n, mask);
            if (m == 4) t = t ^ k[i-3];
            t = t ^ rl(t, n - 1, n, mask);
            k[i] = (~k[i-m] & mask) ^ t ^ 32'(z[61 - ((i - m) % 62)]) ^ 32'd3;
        end
        x = 32'(blk >> n) & mask;
        y = blk[31:0] & mask;
        if (!dec) begin
            for (int i = 0; i < r; i++) begin t = x; x = y ^ fr(x, n, mask) ^ k[i]; y = t; end
        end else begin
            for (int i = r - 1; i >= 0; i--) begin t = y; y = x ^ fr(y, n, mask) ^ k[i]; x = t; end
        end
        return ({32'd0, x} << n) | {32'd0, y};
    endfunction

    function automatic logic [63:0] sb_pop();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic write_key(input logic [1:0] idx, input logic [31:0] w);
        key_we = 1'b1; key_idx = idx; key_word = w;
        @(negedge clk);
        key_we = 1'b0;
    endtask

    // Pulses start and returns the cycle count to done (0 if the budget ran out)
    task automatic launch(input bit dec, input logic [63:0] blk, input int budget, output int lat);
        decrypt = dec; block_in = blk; start = 1'b1;
        lat = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin lat = c; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            dsel = 2'(d); #1;
            n_vec++;
            if ({ack, rdy, busy, done} !== 4'b0000) begin
                n_bad++; $display("FAIL reset_flags dut%0d: ack/ready/busy/done=%b required 0000", d, {ack, rdy, busy, done});
            end
            n_vec++;
            if (bout !== 64'd0) begin
                n_bad++; $display("FAIL reset_block_out dut%0d: got %h required 0", d, bout);
            end
        end
        rst = 1'b0; dsel = 2'd0;
        @(negedge clk);
        start = 1'b1; block_in = 64'h1234; decrypt = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL start_without_key: busy=%b required 0", busy);
        end
    endtask

    task automatic test_key_load_encrypt();
        int lat;
        logic [63:0] e;
        dsel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            write_key(2'(i), key32[32*i +: 32]);
            n_vec++;
            if (ack !== 1'b1 || rdy !== 1'b0) begin
                n_bad++; $display("FAIL key_ack_%0d: ack=%b ready=%b required ack=1 ready=0", i, ack, rdy);
            end
        end
        exp_q.push_back(64'hC69B_E9BB);
        launch(1'b0, 64'h6565_6877, 200, lat);
        n_vec++;
        if (lat !== 61) begin n_bad++; $display("FAIL enc32_latency: got %0d required 61", lat); end
        e = sb_pop();
        n_vec++;
        if (bout !== e) begin n_bad++; $display("FAIL enc32_block: got %h required %h", bout, e); end
        n_vec++;
        if (rdy !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL enc32_status: ready=%b busy=%b required ready=1 busy=0", rdy, busy);
        end
    endtask

    task automatic test_decrypt();
        int lat;
        logic [63:0] e;
        exp_q.push_back(64'h6565_6877);
        launch(1'b1, 64'hC69B_E9BB, 100, lat);
        n_vec++;
        if (lat !== 33) begin n_bad++; $display("FAIL dec32_latency: got %0d required 33", lat); end
        e = sb_pop();
        n_vec++;
        if (bout !== e) begin n_bad++; $display("FAIL dec32_block: got %h required %h", bout, e); end
    endtask

    task automatic test_random_blocks();
        int lat;
        logic [63:0] blk, e;
        for (int i = 0; i < 4; i++) begin
            blk = {32'd0, $urandom};
            exp_q.push_back(model(16, 4, key32, blk, i[0]));
            launch(i[0], blk, 100, lat);
            e = sb_pop();
            n_vec++;
            if (lat !== 33 || bout !== e) begin
                n_bad++; $display("FAIL random_%0d: latency %0d block %h required 33 / %h", i, lat, bout, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [63:0] a, b, e;
        a = {32'd0, $urandom};
        b = {32'd0, $urandom};
        exp_q.push_back(model(16, 4, key32, a, 1'b0));
        exp_q.push_back(model(16, 4, key32, b, 1'b1));
        launch(1'b0, a, 100, lat);
        e = sb_pop();
        n_vec++;
        if (lat !== 33 || bout !== e) begin
            n_bad++; $display("FAIL b2b_first: latency %0d block %h required 33 / %h", lat, bout, e);
        end
        launch(1'b1, b, 100, lat);
        e = sb_pop();
        n_vec++;
        if (lat !== 33 || bout !== e) begin
            n_bad++; $display("FAIL b2b_second: latency %0d block %h required 33 / %h", lat, bout, e);
        end
    endtask

    task automatic test_start_while_busy();
        int lat, ndone;
        logic [63:0] a, b, got, e;
        logic busy_mid;
        a = {32'd0, $urandom};
        b = ~a & 64'hFFFF_FFFF;
        exp_q.push_back(model(16, 4, key32, a, 1'b0));
        lat = 0; ndone = 0; got = '0; busy_mid = 1'b0;
        decrypt = 1'b0; block_in = a; start = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            start = (c == 10);
            block_in = (c == 10) ? b : a;
            decrypt = (c == 10);
            if (c == 10) busy_mid = busy;
            if (done) begin
                ndone++;
                if (lat == 0) begin lat = c; got = bout; end
            end
        end
        e = sb_pop();
        n_vec++;
        if (busy_mid !== 1'b1) begin n_bad++; $display("FAIL busy_in_run: busy=%b required 1", busy_mid); end
        n_vec++;
        if (lat !== 33 || got !== e) begin
            n_bad++; $display("FAIL busy_start_result: latency %0d block %h required 33 / %h", lat, got, e);
        end
        n_vec++;
        if (ndone !== 1) begin n_bad++; $display("FAIL busy_start_dones: got %0d required 1", ndone); end
    endtask

    task automatic test_simultaneous_key_start();
        int lat;
        logic [63:0] e;
        key_we = 1'b1; key_idx = 2'd0; key_word = key32[31:0];
        start = 1'b1; decrypt = 1'b0; block_in = 64'h6565_6877;
        @(negedge clk);
        key_we = 1'b0; start = 1'b0;
        n_vec++;
        if (ack !== 1'b1 || busy !== 1'b0 || rdy !== 1'b0) begin
            n_bad++; $display("FAIL key_start_collision: ack=%b busy=%b ready=%b required 1 0 0", ack, busy, rdy);
        end
        exp_q.push_back(64'hC69B_E9BB);
        launch(1'b0, 64'h6565_6877, 200, lat);
        e = sb_pop();
        n_vec++;
        if (lat !== 61 || bout !== e) begin
            n_bad++; $display("FAIL reexpand: latency %0d block %h required 61 / %h", lat, bout, e);
        end
    endtask

    task automatic test_reset_mid_run();
        int ndone;
        decrypt = 1'b0; block_in = 64'hABCD_1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 50; c++) begin @(negedge clk); if (done) ndone++; end
        n_vec++;
        if (ndone !== 0 || rdy !== 1'b0 || bout !== 64'd0) begin
            n_bad++; $display("FAIL reset_abort: dones %0d ready %b block %h required 0 0 0", ndone, rdy, bout);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL start_after_reset: busy=%b required 0", busy); end
        ndone = 0;
        for (int c = 0; c < 70; c++) begin @(negedge clk); if (done) ndone++; end
        n_vec++;
        if (ndone !== 0) begin n_bad++; $display("FAIL start_after_reset_done: got %0d required 0", ndone); end
    endtask

    task automatic test_simon64();
        int lat;
        logic [63:0] e;
        dsel = 2'd1; #1;
        for (int i = 0; i < 4; i++) begin
            write_key(2'(i), key64[32*i +: 32]);
            n_vec++;
            if (ack !== 1'b1) begin n_bad++; $display("FAIL key64_ack_%0d: ack=%b required 1", i, ack); end
        end
        exp_q.push_back(64'h44c8fc20_b9dfa07a);
        launch(1'b0, 64'h656b696c_20646e75, 200, lat);
        e = sb_pop();
        n_vec++;
        if (lat !== 85 || bout !== e) begin
            n_bad++; $display("FAIL enc64: latency %0d block %h required 85 / %h", lat, bout, e);
        end
        exp_q.push_back(64'h656b696c_20646e75);
        launch(1'b1, 64'h44c8fc20_b9dfa07a, 100, lat);
        e = sb_pop();
        n_vec++;
        if (lat !== 45 || bout !== e) begin
            n_bad++; $display("FAIL dec64: latency %0d block %h required 45 / %h", lat, bout, e);
        end
    endtask

    task automatic test_kw3();
        int lat;
        logic [63:0] blk, e;
        dsel = 2'd2; #1;
        for (int i = 0; i < 3; i++) begin
            write_key(2'(i), key48[32*i +: 32]);
            n_vec++;
            if (ack !== 1'b1) begin n_bad++; $display("FAIL key48_ack_%0d: ack=%b required 1", i, ack); end
        end
        blk = {16'd0, $urandom, 16'(($urandom))};
        exp_q.push_back(model(24, 3, key48, blk, 1'b0));
        launch(1'b0, blk, 200, lat);
        e = sb_pop();
        n_vec++;
        if (lat !== 70 || bout !== e) begin
            n_bad++; $display("FAIL enc48: latency %0d block %h required 70 / %h", lat, bout, e);
        end
        write_key(2'd3, 32'h00FF_FFFF);
        n_vec++;
        if (ack !== 1'b0 || rdy !== 1'b1) begin
            n_bad++; $display("FAIL bad_idx_write: ack=%b ready=%b required 0 1", ack, rdy);
        end
        exp_q.push_back(model(24, 3, key48, blk, 1'b0));
        launch(1'b0, blk, 100, lat);
        e = sb_pop();
        n_vec++;
        if (lat !== 37 || bout !== e) begin
            n_bad++; $display("FAIL enc48_after_bad_write: latency %0d block %h required 37 / %h", lat, bout, e);
        end
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        rst = 1'b1; dsel = 2'd0; key_we = 1'b0; key_idx = 2'd0; key_word = '0;
        start = 1'b0; decrypt = 1'b0; block_in = '0;
        key32 = {32'h1918, 32'h1110, 32'h0908, 32'h0100};
        key64 = 128'h1b1a1918_13121110_0b0a0908_03020100;
        key48 = {32'd0, 8'd0, 24'($urandom), 8'd0, 24'($urandom), 8'd0, 24'($urandom)};
        test_reset();
        test_key_load_encrypt();
        test_decrypt();
        test_random_blocks();
        test_back_to_back();
        test_start_while_busy();
        test_simultaneous_key_start();
        test_reset_mid_run();
        test_simon64();
        test_kw3();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL scoreboard_leftover: %0d entries required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
